// File: rtl/rede_io_server.sv
// I/O port responder for the float processor: per-port input FIFOs served on
// one-hot read strobes, and per-port output registers captured on write strobes.
module rede_io_server #(
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int NBIN   = 19,
    parameter int NBOUT  = 28,
    parameter int FDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUIOIN-1:0]         req_in,
    output logic signed [NBIN-1:0]    io_in,
    input  logic [NUIOOU-1:0]         out_en,
    input  logic signed [NBOUT-1:0]   io_out,
    input  logic [NUIOIN*NBIN-1:0]    src_data,
    input  logic [NUIOIN-1:0]         src_valid,
    output logic [NUIOIN-1:0]         src_ready,
    output logic [NUIOOU*NBOUT-1:0]   snk_data,
    output logic [NUIOOU-1:0]         snk_valid,
    input  logic [NUIOOU-1:0]         snk_ready,
    output logic [NUIOIN-1:0]         underflow,
    output logic [NUIOOU-1:0]         overflow
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FDEPTH);

    logic [NBIN-1:0] mem [NUIOIN][FDEPTH];
    logic [AW-1:0]   wr_ptr [NUIOIN];
    logic [AW-1:0]   rd_ptr [NUIOIN];
    logic [CW-1:0]   count  [NUIOIN];

    logic [NUIOIN-1:0] sel;
    logic [NUIOIN-1:0] push;
    logic [NUIOIN-1:0] pop;
    logic [NUIOIN-1:0] empty_rd;

    // Isolate the lowest set strobe bit; higher bits are ignored entirely.
    assign sel = req_in & (~req_in + NUIOIN'(1));

    always_comb begin
        io_in    = '0;
        push     = '0;
        pop      = '0;
        empty_rd = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            // Ready is forced high while reset is held so producers never see a stale full.
            src_ready[k] = !rst || (count[k] != FULL);
            push[k]      = src_valid[k] && (count[k] != FULL);
            if (sel[k]) begin
                if (count[k] != '0) begin
                    pop[k] = 1'b1;
                    io_in  = mem[k][rd_ptr[k]];
                end else begin
                    empty_rd[k] = 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOIN; k++) begin
            if (rst && push[k])
                mem[k][wr_ptr[k]] <= src_data[k*NBIN +: NBIN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            underflow <= '0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                if (push[k] && !pop[k])
                    count[k] <= count[k] + CW'(1);
                else if (pop[k] && !push[k])
                    count[k] <= count[k] - CW'(1);
            end
            underflow <= underflow | empty_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snk_data  <= '0;
            snk_valid <= '0;
            overflow  <= '0;
        end else begin
            for (int j = 0; j < NUIOOU; j++) begin
                if (out_en[j]) begin
                    snk_data[j*NBOUT +: NBOUT] <= io_out;
                    snk_valid[j]               <= 1'b1;
                    if (snk_valid[j] && !snk_ready[j])
                        overflow[j] <= 1'b1;
                end else if (snk_valid[j] && snk_ready[j]) begin
                    snk_valid[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rede_io_server.sv
// Directed bench for rede_io_server: FIFO order/full, underflow, multi-hot read,
// output overwrite and drain-with-write, plus reset behaviour.
module tb_rede_io_server;

    localparam int NUIOIN = 4;
    localparam int NUIOOU = 4;
    localparam int NBIN   = 19;
    localparam int NBOUT  = 28;
    localparam int FDEPTH = 4;

    logic                      clk;
    logic                      rst;
    logic [NUIOIN-1:0]         req_in;
    logic signed [NBIN-1:0]    io_in;
    logic [NUIOOU-1:0]         out_en;
    logic signed [NBOUT-1:0]   io_out;
    logic [NUIOIN*NBIN-1:0]    src_data;
    logic [NUIOIN-1:0]         src_valid;
    logic [NUIOIN-1:0]         src_ready;
    logic [NUIOOU*NBOUT-1:0]   snk_data;
    logic [NUIOOU-1:0]         snk_valid;
    logic [NUIOOU-1:0]         snk_ready;
    logic [NUIOIN-1:0]         underflow;
    logic [NUIOOU-1:0]         overflow;

    int n_checks = 0;
    int n_errors = 0;

    rede_io_server #(
        .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .NBIN(NBIN), .NBOUT(NBOUT), .FDEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .io_in(io_in),
        .out_en(out_en), .io_out(io_out),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .underflow(underflow), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic signed [63:0] snk(input int j);
        logic signed [NBOUT-1:0] v;
        v = snk_data[j*NBOUT +: NBOUT];
        return v;
    endfunction

    task automatic push1(input int k, input int val);
        src_valid = '0;
        src_data  = '0;
        src_valid[k] = 1'b1;
        src_data[k*NBIN +: NBIN] = NBIN'(val);
        tick();
        src_valid = '0;
    endtask

    int vals [4] = '{5, -3, 7, 100};

    initial begin
        rst       = 1'b0;
        req_in    = '0;
        out_en    = '0;
        io_out    = '0;
        src_data  = '0;
        src_valid = '0;
        snk_ready = '0;
        @(negedge clk);

        // Reset with random inputs
        for (int c = 0; c < 2; c++) begin
            req_in    = NUIOIN'($urandom);
            out_en    = NUIOOU'($urandom);
            io_out    = NBOUT'($urandom);
            src_data  = {$urandom, $urandom, $urandom};
            src_valid = NUIOIN'($urandom);
            snk_ready = NUIOOU'($urandom);
            #1;
            chk("rst_src_ready", src_ready, 4'b1111);
            tick();
        end
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_io_in", io_in, 0);
        req_in = '0; out_en = '0; io_out = '0; src_data = '0; src_valid = '0; snk_ready = '0;
        rst = 1'b1;
        tick();

        // FIFO order and full on port 2
        for (int i = 0; i < 4; i++) push1(2, vals[i]);
        chk("full_src_ready", src_ready, 4'b1011);
        req_in = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fifo_order", io_in, vals[i]);
            tick();
            if (i == 0) chk("ready_after_pop", src_ready[2], 1);
        end
        chk("drained_io_in", io_in, 0);
        req_in = '0;
        chk("no_underflow_yet", underflow, 0);

        // Underflow on port 0
        req_in = 4'b0001;
        #1;
        chk("uf_io_in", io_in, 0);
        tick();
        req_in = '0;
        chk("uf_flag", underflow, 4'b0001);
        push1(0, 11);
        req_in = 4'b0001;
        #1;
        chk("uf_ptr_intact", io_in, 11);
        tick();
        req_in = '0;

        // Multi-hot read: lowest bit wins
        src_data = '0;
        src_data[1*NBIN +: NBIN] = NBIN'(21);
        src_data[3*NBIN +: NBIN] = NBIN'(-33);
        src_valid = 4'b1010;
        tick();
        src_valid = '0;
        req_in = 4'b1010;
        #1;
        chk("mh_io_in", io_in, 21);
        tick();
        chk("mh_no_flags", underflow, 4'b0001);
        req_in = 4'b1000;
        #1;
        chk("mh_port3_kept", io_in, -33);
        tick();
        req_in = 4'b0010;
        #1;
        chk("mh_port1_empty", io_in, 0);
        tick();
        req_in = '0;
        chk("mh_uf1", underflow, 4'b0011);

        // Output overwrite on port 1
        out_en = 4'b0010; io_out = 28'sd1234; snk_ready = '0;
        tick();
        out_en = '0;
        chk("ow_valid", snk_valid, 4'b0010);
        chk("ow_data1", snk(1), 1234);
        chk("ow_no_ovf", overflow, 0);
        out_en = 4'b0010; io_out = NBOUT'(-9);
        tick();
        out_en = '0;
        chk("ow_data2", snk(1), -9);
        chk("ow_ovf", overflow, 4'b0010);

        // Simultaneous drain and write on port 0
        out_en = 4'b0001; io_out = 28'sd7;
        tick();
        chk("dw_pre_valid", snk_valid, 4'b0011);
        out_en = 4'b0001; io_out = 28'sd42; snk_ready = 4'b0001;
        tick();
        out_en = '0; snk_ready = '0;
        chk("dw_valid", snk_valid, 4'b0011);
        chk("dw_data", snk(0), 42);
        chk("dw_ovf", overflow, 4'b0010);
        snk_ready = 4'b0011;
        tick();
        snk_ready = '0;
        chk("drain_valid", snk_valid, 0);
        chk("drain_ovf_sticky", overflow, 4'b0010);
        chk("drain_uf_sticky", underflow, 4'b0011);

        // Reset mid-transfer discards everything
        push1(2, 55);
        out_en = 4'b0100; io_out = 28'sd5;
        tick();
        out_en = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_in = 4'b0100;
        #1;
        chk("mid_rst_io_in", io_in, 0);
        chk("mid_rst_valid", snk_valid, 0);
        chk("mid_rst_flags", {underflow, overflow}, 0);
        chk("mid_rst_data", snk(2), 0);
        tick();
        req_in = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rede_io_server.md
# rede_io_server

Peripheral-side responder for the float processor's I/O port strobes. It serves the one-hot `req_in` read strobes by presenting buffered integer samples on `io_in`, and captures `io_out` into per-port output registers on the one-hot `out_en` write strobes. Each input port is backed by a small FIFO filled by an external valid/ready producer. Each output port drains to an external valid/ready consumer. The block sits outside the processor top, between it and the system datapath.

## Interface
- `NUIOIN`, 4: number of input ports (width of `req_in`).
- `NUIOOU`, 4: number of output ports (width of `out_en`).
- `NBIN`, 19: integer sample width toward the processor (signed).
- `NBOUT`, 28: integer result width from the processor (signed).
- `FDEPTH`, 4: entries per input FIFO; power of two, ≥2.

- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_in`  in  NUIOIN  one-hot read strobe from the processor address decoder.
- `io_in`  out  NBIN  sample to the processor, signed.
- `out_en`  in  NUIOOU  one-hot write strobe from the processor address decoder.
- `io_out`  in  NBOUT  result from the processor, signed.
- `src_data`  in  NUIOIN*NBIN  producer data; port k occupies bits [k*NBIN +: NBIN].
- `src_valid`  in  NUIOIN  producer valid, per port.
- `src_ready`  out  NUIOIN  FIFO not full, per port.
- `snk_data`  out  NUIOOU*NBOUT  captured results; port k occupies bits [k*NBOUT +: NBOUT].
- `snk_valid`  out  NUIOOU  output register holds unconsumed data.
- `snk_ready`  in  NUIOOU  consumer accepts, per port.
- `underflow`  out  NUIOIN  sticky: read of an empty FIFO.
- `overflow`  out  NUIOOU  sticky: overwrite of unconsumed output.

## Operation
**Input FIFOs (per port k)**
- Circular buffer with wr/rd pointers of log2(FDEPTH) bits and a count of log2(FDEPTH)+1 bits. Pointers wrap modulo FDEPTH.
- `src_ready[k] = (count != FDEPTH)`. The decision uses the registered count, so a full FIFO does not accept a push even if it pops in the same cycle.
- Push when `src_valid[k] && src_ready[k]`.
- Pop when port k is selected by `req_in` and `count != 0`.
- Simultaneous push and pop: both occur, count unchanged.

**Read selection**
- The lowest set bit of `req_in` selects the port. Any other set bits are ignored: no pop and no flag for them.
- `io_in` is the head of the selected FIFO, combinational.
- `io_in = 0` when `req_in == 0` or when the selected FIFO is empty.
- Selected FIFO empty: `underflow[k]` is set; count and pointers do not change.

**Output registers (per port j)**
- On `out_en[j]`:
  - `snk_data` slice j ← `io_out`, and `snk_valid[j]` ← 1.
  - If `snk_valid[j]` was already 1 and `snk_ready[j]` is 0 in that cycle, the old data is overwritten and `overflow[j]` is set.
- `out_en[j]` and a drain (`snk_valid[j] && snk_ready[j]`) in the same cycle: the new data loads, `snk_valid[j]` stays 1, no overflow.
- Drain without `out_en[j]`: `snk_valid[j]` ← 0.
- `out_en` multi-hot: every set bit captures the same `io_out` value; the processor never does this, and the block does not treat it as an error.

**Reset** (`rst == 0` at a clock edge)
- All counts and pointers ← 0, `snk_valid` ← 0, `snk_data` ← 0, `underflow` and `overflow` ← 0.
- FIFO storage contents are don't-care.
- Reset mid-transfer discards all buffered and unconsumed data.
- Sticky flags clear only on reset.

## Timing
- Read latency is 0 cycles: `io_in` is valid in the same cycle `req_in` is asserted. The pop commits at that cycle's edge.
- A pushed sample can be read starting in the cycle after the push.
- `snk_valid[j]` rises in the cycle after `out_en[j]` and falls in the cycle after the accepting edge.
- Flags rise in the cycle after the offending strobe.
- Output values during and immediately after reset:
  - `src_ready` = all ones during reset.
  - `io_in` follows the combinational rule above; with all counts at 0 it reads 0.
- Back-to-back `req_in` to the same port pops one entry per cycle.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles with random inputs → `snk_valid=0`, `underflow=0`, `overflow=0`, `src_ready=4'b1111`, `io_in=0`.
- **FIFO order and full:** push 5, -3, 7, 100 into port 2 → `src_ready[2]=0`. Then `req_in=4'b0100` for 4 cycles → `io_in` reads 5, -3, 7, 100 in order, and `src_ready[2]=1` after the first pop.
- **Underflow:** `req_in=4'b0001` with port 0 empty → `io_in=0`, `underflow=4'b0001` next cycle, count stays 0.
- **Multi-hot read:** ports 1 and 3 each hold one sample, `req_in=4'b1010` → port 1's sample appears on `io_in`, port 1 count 1→0, port 3 count stays 1, no flags.
- **Output overwrite:**
  - `out_en=4'b0010` with `io_out=28'sd1234`, `snk_ready=0` → `snk_valid[1]=1` next cycle with data 1234.
  - Then `out_en=4'b0010` with `io_out=-9` and `snk_ready=0` → data -9, `overflow[1]=1`.
- **Simultaneous drain and write:** `snk_valid[0]=1` and `snk_ready[0]=1` in the same cycle as `out_en[0]` with `io_out=42` → `snk_valid[0]` stays 1, data 42, `overflow[0]=0`.
